m_fetch: RTL and testbench

Instruction fetch stage of the core. Generates sequential 32-bit instruction addresses, issues them to the instruction memory port, and tracks in-flight requests. Buffers returned words in a small queue and presents them, with their PCs, to `m_decoder` over a valid/ready handshake. Supports redirects from the back end by discarding stale in-flight responses.

---
 rtl/m_fetch_pkg.sv | 35 +++
 rtl/m_fetch_if.sv | 51 +++++
 rtl/m_fifo.sv | 60 ++++++
 rtl/m_fetch.sv | 134 +++++++++++++
 tb/tb_m_fetch.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_fetch_pkg.sv
// Shared core types for the front end: fetched and decoded bundles,
// instruction size, default boot PC, and the fetch FSM state encoding.
package m_fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One queued fetch result handed to m_decoder.
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic        fault;
    } s_fetched;

    // Decoder output bundle, consumed by issue.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        fault;
    } s_decoded;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } e_fetch_state;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/m_fetch_if.sv
// Fetch-stage bus: instruction memory request/response, back-end redirect
// and the decoder handshake. master = fetch stage, slave = its environment.
interface m_fetch_if;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_error;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instruction_valid;
    logic        instruction_ready;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic        instruction_fault;

    modport master (
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_addr,
        input  mem_resp_valid,
        input  mem_resp_data,
        input  mem_resp_error,
        input  redirect_valid,
        input  redirect_pc,
        output instruction_valid,
        input  instruction_ready,
        output instruction,
        output instruction_pc,
        output instruction_fault
    );

    modport slave (
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_addr,
        output mem_resp_valid,
        output mem_resp_data,
        output mem_resp_error,
        output redirect_valid,
        output redirect_pc,
        input  instruction_valid,
        output instruction_ready,
        input  instruction,
        input  instruction_pc,
        input  instruction_fault
    );

endinterface

// File: rtl/m_fifo.sv
// Synchronous FIFO of s_fetched entries with flush.
// Ports: clk, reset, flush, push/push_data, pop, head, empty, count.
module m_fifo
    import m_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  s_fetched                 push_data,
    input  logic                     pop,
    output s_fetched                 head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    s_fetched          mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible below count.
    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
    end

    // The fetch credit scheme must never push into a full queue.
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && full))
                else $error("m_fifo: push into full queue");
        end
    end

endmodule

// File: rtl/m_fetch.sv
// Instruction fetch stage: sequential PC generation, in-flight tracking,
// stale-response discard on redirect, and queued delivery to m_decoder.
// Ports: clk, reset (sync, active-high), bus (m_fetch_if.master).
module m_fetch
    import m_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    m_fetch_if.master   bus
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = $clog2(QUEUE_DEPTH) + 1;

    e_fetch_state    state;
    e_fetch_state    state_next;
    logic [31:0]     fetch_pc;
    logic [31:0]     resp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   outstanding_next;
    logic [OW-1:0]   discard;
    logic [31:0]     redirect_aligned;

    logic            req_valid;
    logic            accept;
    logic            pop;
    logic            resp_take;
    logic            push;
    logic            credit_ok;

    s_fetched        push_data;
    s_fetched        head;
    logic            empty;
    logic [QW-1:0]   count;

    assign redirect_aligned = word_align(bus.redirect_pc);
    assign pop       = !empty && bus.instruction_ready;
    // A response with nothing in flight can only be a leftover from
    // before reset; it is ignored so the counters never underflow.
    assign resp_take = bus.mem_resp_valid && (outstanding != '0);
    assign push      = resp_take && (discard == '0)
                     && (state == ST_RUN) && !bus.redirect_valid;
    assign accept    = req_valid && bus.mem_req_ready;

    // Reserve a queue slot for every in-flight request so that a
    // returning response always has room.
    assign credit_ok = (int'(count) + int'(outstanding) - int'(pop))
                     < QUEUE_DEPTH;

    assign outstanding_next = outstanding + OW'(accept) - OW'(resp_take);

    always_comb begin
        push_data             = '0;
        push_data.pc          = resp_pc;
        push_data.fault       = bus.mem_resp_error;
        push_data.instruction = bus.mem_resp_error ? 32'h0 : bus.mem_resp_data;
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_next;
    end

    // FSM: next state.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (push && bus.mem_resp_error) state_next = ST_HALT;
            end
            ST_HALT: begin
                if (bus.redirect_valid) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // FSM: outputs.
    always_comb begin
        req_valid = 1'b0;
        if (!reset && state == ST_RUN && !bus.redirect_valid
            && int'(outstanding) < MAX_OUTSTANDING && credit_ok) begin
            req_valid = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (bus.redirect_valid) begin
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                // Everything still in flight belongs to the old path.
                discard  <= outstanding_next;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
                if (push)   resp_pc  <= resp_pc + 32'(INSTR_BYTES);
                if (resp_take && discard != '0) discard <= discard - OW'(1);
            end
        end
    end

    m_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .count     (count)
    );

    assign bus.mem_req_valid     = req_valid;
    assign bus.mem_req_addr      = fetch_pc;
    assign bus.instruction_valid = !empty;
    assign bus.instruction       = empty ? 32'h0 : head.instruction;
    assign bus.instruction_pc    = empty ? 32'h0 : head.pc;
    assign bus.instruction_fault = !empty && head.fault;

endmodule

// File: tb/tb_m_fetch.sv
// Self-checking bench for m_fetch: directed scenarios plus a randomized
// run scored against a path-level model of the fetched instruction stream.
module tb_m_fetch;
    import m_fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int QD = 4;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    m_fetch_if bus ();

    m_fetch #(
        .RESET_PC        (RPC),
        .QUEUE_DEPTH     (QD),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        mq[$];
    s_fetched    got_q[$];
    s_fetched    exp_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] eacc_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int epoch = 0;
    int last_due = 0;
    int p_ready = 100;
    int lat_lo = 1;
    int lat_hi = 1;
    int budget = -1;
    int proto_bad = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic [31:0] fault_addr = 32'h0;
    bit          fault_en = 0;
    bit          halted = 0;
    bit          popped_fault = 0;

    logic        obs_rv;
    logic [31:0] obs_ra;
    logic        obs_iv;
    logic [31:0] obs_pc;
    bit          obs_acc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        acc_q.delete();
        eacc_q.delete();
    endtask

    // Holds reset for two edges and returns at a falling edge with reset
    // still high; the next tick releases it. The memory is reset too.
    task automatic do_reset();
        reset = 1'b1;
        bus.mem_req_ready     = 1'b0;
        bus.mem_resp_valid    = 1'b0;
        bus.mem_resp_data     = 32'h0;
        bus.mem_resp_error    = 1'b0;
        bus.redirect_valid    = 1'b0;
        bus.redirect_pc       = 32'h0;
        bus.instruction_ready = 1'b0;
        mq.delete();
        epoch++;
        exp_pc = RPC;
        exp_req = RPC;
        halted = 0;
        popped_fault = 0;
        last_due = 0;
        budget = -1;
        repeat (2) @(posedge clk);
        cyc += 2;
        @(negedge clk);
    endtask

    // One clock cycle: drive inputs, run the memory and stream model,
    // record observations, advance to the next falling edge.
    task automatic tick(input bit redir, input logic [31:0] rpc,
                        input bit iready);
        bit          rv;
        bit          fl;
        req_t        r;
        s_fetched    g;
        s_fetched    e;
        logic [31:0] ea;
        reset = 1'b0;
        bus.redirect_valid    = redir;
        bus.redirect_pc       = rpc;
        bus.instruction_ready = iready;
        bus.mem_req_ready = (budget != 0) && ($urandom_range(99) < p_ready);
        rv = (mq.size() > 0);
        if (rv) rv = (mq[0].due <= cyc);
        bus.mem_resp_valid = rv;
        bus.mem_resp_data  = 32'h0;
        bus.mem_resp_error = 1'b0;
        if (rv) begin
            bus.mem_resp_data  = mem_word(mq[0].addr);
            bus.mem_resp_error = fault_en && (mq[0].addr == fault_addr);
        end
        #1;
        obs_rv  = bus.mem_req_valid;
        obs_ra  = bus.mem_req_addr;
        obs_iv  = bus.instruction_valid;
        obs_pc  = bus.instruction_pc;
        obs_acc = bus.mem_req_valid && bus.mem_req_ready;
        if (halted && bus.mem_req_valid) proto_bad++;
        if (bus.instruction_valid && iready && !redir) begin
            if (popped_fault) begin
                proto_bad++;
            end else begin
                g.instruction = bus.instruction;
                g.pc          = bus.instruction_pc;
                g.fault       = bus.instruction_fault;
                got_q.push_back(g);
                ea = exp_pc;
                fl = fault_en && (ea == fault_addr);
                e.instruction = fl ? 32'h0 : mem_word(ea);
                e.pc          = ea;
                e.fault       = fl;
                exp_q.push_back(e);
                exp_pc = exp_pc + 32'd4;
                if (fl) popped_fault = 1;
            end
        end
        if (obs_acc) begin
            if (mq.size() >= MO) proto_bad++;
            acc_q.push_back(bus.mem_req_addr);
            eacc_q.push_back(exp_req);
            exp_req = exp_req + 32'd4;
            r.addr  = bus.mem_req_addr;
            r.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (r.due < last_due) r.due = last_due;
            last_due = r.due;
            r.epoch = epoch;
            mq.push_back(r);
            if (budget > 0) budget--;
        end
        if (rv) begin
            r = mq.pop_front();
            if (r.epoch == epoch && !halted && !redir && bus.mem_resp_error)
                halted = 1;
        end
        if (redir) begin
            epoch++;
            exp_pc = {rpc[31:2], 2'b00};
            exp_req = {rpc[31:2], 2'b00};
            halted = 0;
            popped_fault = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid: got %b want 0", bus.mem_req_valid);
        end
        checks++;
        if (bus.instruction_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ivalid: got %b want 0", bus.instruction_valid);
        end
        checks++;
        if ({bus.instruction, bus.instruction_pc, bus.instruction_fault}
            !== 65'h0) begin
            errors++;
            $display("FAIL reset_head: got %h/%h/%b want 0/0/0",
                     bus.instruction, bus.instruction_pc,
                     bus.instruction_fault);
        end
        p_ready = 100;
        lat_lo = 1;
        lat_hi = 1;
        tick(0, 32'h0, 1);
        checks++;
        if (obs_rv !== 1'b1 || obs_ra !== RPC) begin
            errors++;
            $display("FAIL first_req: got v=%b a=%h want v=1 a=%h",
                     obs_rv, obs_ra, RPC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        clear_logs();
        p_ready = 100;
        lat_lo = 1;
        lat_hi = 1;
        for (int c = 0; c < 12; c++) begin
            tick(0, 32'h0, 1);
            if (c >= 2) begin
                checks++;
                if (obs_iv !== 1'b1 || obs_pc !== RPC + 32'(4 * (c - 2))) begin
                    errors++;
                    $display("FAIL stream_c%0d: got v=%b pc=%h want v=1 pc=%h",
                             c, obs_iv, obs_pc, RPC + 32'(4 * (c - 2)));
                end
            end
        end
        checks++;
        if (got_q.size() != 10) begin
            errors++;
            $display("FAIL stream_count: got %0d want 10", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stream_word%0d: got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick(0, 32'h0, 0);
            if (obs_acc) n++;
        end
        checks++;
        if (n != QD) begin
            errors++;
            $display("FAIL bp_requests: got %0d want %0d", n, QD);
        end
        checks++;
        if (obs_rv !== 1'b0) begin
            errors++;
            $display("FAIL bp_req_valid: got %b want 0", obs_rv);
        end
        checks++;
        if (obs_iv !== 1'b1 || obs_pc !== RPC) begin
            errors++;
            $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=%h",
                     obs_iv, obs_pc, RPC);
        end
        tick(0, 32'h0, 1);
        checks++;
        if (obs_rv !== 1'b1 || obs_ra !== RPC + 32'd16) begin
            errors++;
            $display("FAIL bp_resume: got v=%b a=%h want v=1 a=%h",
                     obs_rv, obs_ra, RPC + 32'd16);
        end
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        p_ready = 100;
        lat_lo = 10;
        lat_hi = 10;
        budget = 3;
        n = 0;
        repeat (3) begin
            tick(0, 32'h0, 1);
            if (obs_acc) n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL redir_inflight: got %0d want 3", n);
        end
        tick(1, 32'h0000_1002, 1);
        checks++;
        if (obs_rv !== 1'b0) begin
            errors++;
            $display("FAIL redir_cycle_req: got %b want 0", obs_rv);
        end
        budget = -1;
        lat_lo = 1;
        lat_hi = 1;
        clear_logs();
        tick(0, 32'h0, 1);
        checks++;
        if (obs_rv !== 1'b1 || obs_ra !== 32'h0000_1000) begin
            errors++;
            $display("FAIL redir_new_req: got v=%b a=%h want v=1 a=00001000",
                     obs_rv, obs_ra);
        end
        repeat (25) tick(0, 32'h0, 1);
        checks++;
        if (got_q.size() == 0 || got_q[0].pc !== 32'h0000_1000) begin
            errors++;
            $display("FAIL redir_first_pc: got n=%0d want first pc 00001000",
                     got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL redir_word%0d: got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_fault();
        int pb;
        do_reset();
        clear_logs();
        pb = proto_bad;
        p_ready = 100;
        lat_lo = 1;
        lat_hi = 1;
        fault_en = 1;
        fault_addr = 32'h8;
        repeat (10) tick(0, 32'h0, 1);
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL fault_count: got %0d want 3", got_q.size());
        end
        checks++;
        if (got_q.size() < 3 || got_q[2].instruction !== 32'h0
            || got_q[2].pc !== 32'h8 || got_q[2].fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_entry: got n=%0d want {0,00000008,1}",
                     got_q.size());
        end
        checks++;
        if (obs_rv !== 1'b0 || proto_bad != pb) begin
            errors++;
            $display("FAIL fault_halt: got v=%b bad=%0d want v=0 bad=%0d",
                     obs_rv, proto_bad, pb);
        end
        tick(1, 32'h40, 1);
        fault_en = 0;
        tick(0, 32'h0, 1);
        checks++;
        if (obs_rv !== 1'b1 || obs_ra !== 32'h40) begin
            errors++;
            $display("FAIL fault_resume: got v=%b a=%h want v=1 a=00000040",
                     obs_rv, obs_ra);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        p_ready = 100;
        lat_lo = 1;
        lat_hi = 1;
        tick(1, 32'hFFFF_FFFC, 1);
        clear_logs();
        repeat (6) tick(0, 32'h0, 1);
        checks++;
        if (acc_q.size() < 2 || acc_q[0] !== 32'hFFFF_FFFC
            || acc_q[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_req: got n=%0d want FFFFFFFC then 00000000",
                     acc_q.size());
        end
        checks++;
        if (got_q.size() < 2 || got_q[0] !== exp_q[0]
            || got_q[1] !== exp_q[1] || got_q[1].pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_deliver: got n=%0d want pcs FFFFFFFC,0",
                     got_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        p_ready = 100;
        lat_lo = 1;
        lat_hi = 1;
        repeat (3) tick(0, 32'h0, 0);
        checks++;
        if (obs_iv !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre: got ivalid=%b want 1", obs_iv);
        end
        do_reset();
        checks++;
        if (bus.instruction_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_cleared: got iv=%b rv=%b want 0/0",
                     bus.instruction_valid, bus.mem_req_valid);
        end
        tick(0, 32'h0, 1);
        checks++;
        if (obs_rv !== 1'b1 || obs_ra !== RPC) begin
            errors++;
            $display("FAIL rmid_first_req: got v=%b a=%h want v=1 a=%h",
                     obs_rv, obs_ra, RPC);
        end
    endtask

    task automatic test_random();
        int          pb;
        bit          ir;
        bit          rd;
        logic [31:0] rpc;
        do_reset();
        clear_logs();
        pb = proto_bad;
        p_ready = 70;
        lat_lo = 1;
        lat_hi = 4;
        fault_en = 1;
        fault_addr = 32'($urandom_range(127)) * 32'd4;
        for (int i = 0; i < 3000; i++) begin
            ir = ($urandom_range(99) < 75);
            rd = ($urandom_range(99) < 2)
              || (popped_fault && $urandom_range(99) < 20);
            rpc = 32'h0;
            if (rd) begin
                if ($urandom_range(9) == 0)
                    rpc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                else
                    rpc = 32'($urandom_range(255));
                fault_addr = 32'($urandom_range(127)) * 32'd4;
            end
            tick(rd, rpc, ir);
        end
        fault_en = 0;
        checks++;
        if (got_q.size() != exp_q.size() || got_q.size() < 300) begin
            errors++;
            $display("FAIL rand_count: got %0d model %0d want equal and >=300",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_word%0d: got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < acc_q.size(); i++) begin
            checks++;
            if (acc_q[i] !== eacc_q[i]) begin
                errors++;
                $display("FAIL rand_req%0d: got %h want %h",
                         i, acc_q[i], eacc_q[i]);
            end
        end
        checks++;
        if (proto_bad != pb) begin
            errors++;
            $display("FAIL rand_protocol: got %0d violations want 0",
                     proto_bad - pb);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
